// File: rtl/demux32_1_4_buf_if.sv
// rtl/demux32_1_4_buf_if.sv - stream and lane signal bundle for the 1:4 buffered demux
// Purpose: groups the input stream, the four output lanes and the occupancy
//          bus so they can be passed to the demux as a single port.
// Signals:
//   in_data/in_sel/in_valid   source word, destination lane, valid
//   in_ready                  selected lane can accept
//   out_data/out_valid        lane k head = out_data[k*W +: W], head valid
//   out_ready                 lane k consumer accepts
//   lane_cnt                  lane k occupancy = lane_cnt[k*CW +: CW]
// Modports: master = source/consumer side, slave = demux side.
interface demux32_1_4_buf_if #(
   parameter int W     = 32,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [W-1:0]    in_data;
   logic [1:0]      in_sel;
   logic            in_valid;
   logic            in_ready;
   logic [4*W-1:0]  out_data;
   logic [3:0]      out_valid;
   logic [3:0]      out_ready;
   logic [4*CW-1:0] lane_cnt;

   modport master (
      output in_data, in_sel, in_valid, out_ready,
      input  in_ready, out_data, out_valid, lane_cnt
   );

   modport slave (
      input  in_data, in_sel, in_valid, out_ready,
      output in_ready, out_data, out_valid, lane_cnt
   );
endinterface

// File: rtl/demux32_1_4_buf.sv
// rtl/demux32_1_4_buf.sv - one-stream to four-lane demux with a FIFO per lane
// Purpose: routes each accepted input word to the lane named by in_sel. Every
//          lane owns a DEPTH-entry FIFO with its own valid/ready, so a stalled
//          consumer only back-pressures words aimed at its own lane.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, empties every lane
//   flush  synchronous clear of all lanes, wins over push and pop
//   bus    demux32_1_4_buf_if.slave (input stream, four lanes, occupancy)
module demux32_1_4_buf #(
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   demux32_1_4_buf_if.slave     bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [W-1:0]  mem_q  [4][DEPTH];
   logic [W-1:0]  mem_d  [4][DEPTH];
   logic [AW-1:0] rptr_q [4];
   logic [AW-1:0] rptr_d [4];
   logic [AW-1:0] wptr_q [4];
   logic [AW-1:0] wptr_d [4];
   logic [CW-1:0] cnt_q  [4];
   logic [CW-1:0] cnt_d  [4];
   // Registered head per lane: keeps the last delivered word visible once a
   // lane drains, instead of exposing whatever stale entry rptr lands on.
   logic [W-1:0]  head_q [4];
   logic [W-1:0]  head_d [4];

   logic push_ok;

   // Readiness looks only at the selected lane's stored count, never at
   // out_ready, so a full lane refuses even when it is popping this cycle.
   assign bus.in_ready = (cnt_q[bus.in_sel] != FULL) && !flush;
   assign push_ok      = bus.in_valid && bus.in_ready;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         logic push_k;
         logic pop_k;
         mem_d[k]  = mem_q[k];
         rptr_d[k] = rptr_q[k];
         wptr_d[k] = wptr_q[k];
         cnt_d[k]  = cnt_q[k];
         push_k    = push_ok && (bus.in_sel == 2'(k));
         pop_k     = (cnt_q[k] != '0) && bus.out_ready[k];
         if (flush) begin
            rptr_d[k] = '0;
            wptr_d[k] = '0;
            cnt_d[k]  = '0;
         end else begin
            if (push_k) begin
               mem_d[k][wptr_q[k]] = bus.in_data;
               wptr_d[k]           = wptr_q[k] + AW'(1);
            end
            if (pop_k) begin
               rptr_d[k] = rptr_q[k] + AW'(1);
            end
            if (push_k && !pop_k) begin
               cnt_d[k] = cnt_q[k] + CW'(1);
            end else if (pop_k && !push_k) begin
               cnt_d[k] = cnt_q[k] - CW'(1);
            end
         end
         // Next head is read from the post-write array so a word pushed into
         // an empty lane appears right after its push edge.
         head_d[k] = (cnt_d[k] != '0) ? mem_d[k][rptr_d[k]] : head_q[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) begin
            for (int e = 0; e < DEPTH; e++) begin
               mem_q[k][e] <= '0;
            end
            rptr_q[k] <= '0;
            wptr_q[k] <= '0;
            cnt_q[k]  <= '0;
            head_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            mem_q[k]  <= mem_d[k];
            rptr_q[k] <= rptr_d[k];
            wptr_q[k] <= wptr_d[k];
            cnt_q[k]  <= cnt_d[k];
            head_q[k] <= head_d[k];
         end
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_lane
      assign bus.out_data[g*W +: W]   = head_q[g];
      assign bus.out_valid[g]         = (cnt_q[g] != '0);
      assign bus.lane_cnt[g*CW +: CW] = cnt_q[g];
   end
endmodule
